// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO: read-mode selector and sticky error flags.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  // Write the addressed word on an enabled rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with level flags, sticky error flags and
// selectable registered-read or first-word-fall-through output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_LVL);
  localparam fifo_mode_t MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two and at least 4");
  end
  if (AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_LVL must not exceed DEPTH");
  end
  if (AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
    $error("param_sync_fifo: AEMPTY_LVL must be below DEPTH");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;
  fifo_err_t             err_q;
  fifo_err_t             err_set;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // The wrap bit makes the pointer difference an exact 0..DEPTH occupancy.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_V);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_V);
  assign almost_empty = (count <= AEMPTY_V);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // Accept/reject decisions; a rejected request raises its error flag even
  // when the opposite operation is accepted in the same cycle.
  always_comb begin
    push_acc          = push & ~full;
    pop_acc           = pop & ~empty;
    err_set.overflow  = push & full;
    err_set.underflow = pop & empty;
  end

  // Pointer advance; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= err_set.overflow  | (err_q.overflow  & ~clr_err);
      err_q.underflow <= err_set.underflow | (err_q.underflow & ~clr_err);
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: capture the head word on an accepted pop, hold otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_acc;
        if (pop_acc) rd_data_q <= ram_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is always presented; pop just advances past it.
    assign rd_data  = ram_rdata;
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a registered-read and a fall-through FIFO (DEPTH=4) driven
// by the same stimulus, with hand-computed expected values.
module tb_param_sync_fifo;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [2:0]    s_count, f_count;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then land 1 time unit after the rising edge.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q,
                     input logic c, input logic r);
    push = p; wr_data = d; pop = q; clr_err = c; reset = r;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_both_count(input string tag, input logic [2:0] exp);
    chk({tag, "_s_count"}, s_count, exp);
    chk({tag, "_f_count"}, f_count, exp);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_both_count("rst", 3'd0);
    chk("rst_empty", s_empty, 1);
    chk("rst_aempty", s_aempty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_afull", s_afull, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_valid", f_rd_valid, 0);
    chk("rst_s_valid", s_rd_valid, 0);
    chk("rst_s_data", s_rd_data, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);

    // Fill with 0xA..0xD, checking level flags on the way
    cyc(1, 8'h0A, 0, 0, 0);
    chk_both_count("fill1", 3'd1);
    chk("fill1_afull", s_afull, 0);
    chk("fill1_aempty", s_aempty, 1);
    chk("fill1_f_valid", f_rd_valid, 1);
    chk("fill1_f_data", f_rd_data, 8'h0A);
    cyc(1, 8'h0B, 0, 0, 0);
    chk("fill2_afull", s_afull, 1);
    chk("fill2_aempty", s_aempty, 1);
    cyc(1, 8'h0C, 0, 0, 0);
    chk("fill3_aempty", s_aempty, 0);
    chk("fill3_full", s_full, 0);
    cyc(1, 8'h0D, 0, 0, 0);
    chk_both_count("fill4", 3'd4);
    chk("fill4_full", s_full, 1);
    chk("fill4_f_full", f_full, 1);
    chk("fill4_empty", s_empty, 0);

    // Drain, checking a single-cycle rd_valid per pop
    for (int i = 0; i < 4; i++) begin
      chk("drain_f_head", f_rd_data, 8'h0A + i);
      cyc(0, 0, 1, 0, 0);
      chk("drain_s_data", s_rd_data, 8'h0A + i);
      chk("drain_s_valid", s_rd_valid, 1);
      cyc(0, 0, 0, 0, 0);
      chk("drain_s_valid_low", s_rd_valid, 0);
      chk("drain_s_data_hold", s_rd_data, 8'h0A + i);
    end
    chk("drain_empty", s_empty, 1);
    chk("drain_f_valid", f_rd_valid, 0);
    chk("drain_udf", s_udf, 0);

    // Push into full FIFO while popping: push dropped, overflow set
    for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0, 0, 0);
    cyc(1, 8'h0E, 1, 0, 0);
    chk("ovf_s_data", s_rd_data, 8'h01);
    chk("ovf_flag", s_ovf, 1);
    chk("ovf_f_flag", f_ovf, 1);
    chk_both_count("ovf", 3'd3);
    chk("ovf_f_head", f_rd_data, 8'h02);
    cyc(0, 0, 0, 1, 0);
    chk("ovf_clr", s_ovf, 0);
    chk("ovf_f_clr", f_ovf, 0);
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("ovf_drain", s_rd_data, DW'(i));
    end
    chk("ovf_drop_empty", s_empty, 1);

    // Underflow with clr_err in the same cycle: set wins
    cyc(0, 0, 1, 1, 0);
    chk("udf_setwins", s_udf, 1);
    chk("udf_s_valid", s_rd_valid, 0);
    cyc(0, 0, 0, 1, 0);
    chk("udf_clr", s_udf, 0);

    // Push and pop together into empty: pop ignored, push kept
    cyc(1, 8'h05, 1, 0, 0);
    chk("pp_udf", s_udf, 1);
    chk("pp_f_udf", f_udf, 1);
    chk_both_count("pp", 3'd1);
    chk("pp_s_valid", s_rd_valid, 0);
    chk("pp_f_data", f_rd_data, 8'h05);
    cyc(0, 0, 1, 0, 0);
    chk("pp_pop_data", s_rd_data, 8'h05);
    chk("pp_pop_empty", f_empty, 1);
    cyc(0, 0, 0, 1, 0);

    // Fall-through: word visible with no pop, then consumed
    cyc(1, 8'h77, 0, 0, 0);
    chk("fw_valid", f_rd_valid, 1);
    chk("fw_data", f_rd_data, 8'h77);
    cyc(0, 0, 0, 0, 0);
    chk("fw_hold_valid", f_rd_valid, 1);
    chk("fw_hold_data", f_rd_data, 8'h77);
    cyc(0, 0, 1, 0, 0);
    chk("fw_pop_empty", f_empty, 1);
    chk("fw_pop_valid", f_rd_valid, 0);
    chk("fw_s_data", s_rd_data, 8'h77);

    // Pointer wrap: 10 push/pop pairs with one word resident
    cyc(1, 8'h10, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_f_head", f_rd_data, 8'h10 + i);
      cyc(1, 8'h11 + i, 1, 0, 0);
      chk("wrap_s_data", s_rd_data, 8'h10 + i);
      chk_both_count("wrap", 3'd1);
    end
    cyc(0, 0, 1, 0, 0);
    chk("wrap_last", s_rd_data, 8'h1A);
    chk("wrap_empty", s_empty, 1);
    chk("wrap_errs", {s_ovf, s_udf, f_ovf, f_udf}, 4'b0000);

    // Reset mid-operation with count=3 and both errors set
    cyc(0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'h20 + i, 0, 0, 0);
    cyc(1, 8'h25, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_both_count("prerst", 3'd3);
    chk("prerst_errs", {s_ovf, s_udf}, 2'b11);
    push = 1'b1; wr_data = 8'h99; pop = 1'b1; clr_err = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; reset = 1'b0;
    chk_both_count("mrst", 3'd0);
    chk("mrst_empty", s_empty, 1);
    chk("mrst_f_empty", f_empty, 1);
    chk("mrst_errs", {s_ovf, s_udf, f_ovf, f_udf}, 4'b0000);
    chk("mrst_s_valid", s_rd_valid, 0);
    chk("mrst_s_data", s_rd_data, 0);
    cyc(0, 0, 0, 0, 0);
    chk_both_count("postrst", 3'd0);
    cyc(1, 8'h30, 0, 0, 0);
    chk("postrst_f_data", f_rd_data, 8'h30);
    cyc(0, 0, 1, 0, 0);
    chk("postrst_s_data", s_rd_data, 8'h30);
    chk("postrst_empty", s_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, >=4.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, almost_full asserts when count >= AFULL_LVL.
REQ-004 Parameter AEMPTY_LVL, default 2, almost_empty asserts when count <= AEMPTY_LVL.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 push  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write data, sampled when push is accepted.
REQ-010 pop  input  1  read request.
REQ-011 rd_data  output  DATA_WIDTH  read data.
REQ-012 rd_valid  output  1  rd_data holds a valid word.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  level flags.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 clr_err  input  1  clears overflow and underflow.

Function
REQ-017 Storage SHALL hold exactly DEPTH words; full SHALL mean count==DEPTH, empty SHALL mean count==0.
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit; address = lower bits; wrap from DEPTH-1 to 0 is silent.
REQ-019 Push accepted = push & ~full; word written at wr_ptr; wr_ptr increments the same edge.
REQ-020 Pop accepted = pop & ~empty; rd_ptr increments the same edge.
REQ-021 Push while full SHALL be dropped and SHALL set overflow, even if pop is accepted in the same cycle.
REQ-022 Pop while empty SHALL be ignored and SHALL set underflow, even if push is accepted in the same cycle.
REQ-023 Push and pop both accepted SHALL leave count unchanged; otherwise count moves +1 or -1 per accepted push or pop.
REQ-024 Flags and count SHALL be registered-state-derived and SHALL reflect all accepted operations one cycle after the edge.
REQ-025 FWFT=0: on an accepted pop, rd_data SHALL load the head word at that edge; rd_valid SHALL be high for exactly the following cycle; rd_data holds its value otherwise.
REQ-026 FWFT=1: rd_data SHALL combinationally present the word at rd_ptr; rd_valid SHALL equal ~empty; pop consumes the presented word.
REQ-027 FWFT=1: a word pushed into an empty FIFO SHALL appear on rd_data with rd_valid high in the cycle after the push edge.
REQ-028 overflow and underflow SHALL stay set until clr_err; when clr_err and a new error occur in the same cycle, set wins.

Reset
REQ-029 Reset SHALL clear wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow and underflow to 0.
REQ-030 During and after reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words and take priority over push, pop and clr_err.
REQ-032 RAM contents SHALL NOT be reset.

Structure
REQ-033 Package fifo_pkg SHALL hold the mode enum (FIFO_STD, FIFO_FWFT) and the error-flag struct typedef.
REQ-034 Storage SHALL be in sub-module fifo_dp_ram: one write port (clk, we, waddr, wdata) and one combinational read port (raddr, rdata).
REQ-035 Elaboration SHALL fail for non-power-of-two DEPTH, for AFULL_LVL > DEPTH, and for AEMPTY_LVL >= DEPTH.

Verification
REQ-036 DEPTH=4, FWFT=0: push 0xA,0xB,0xC,0xD -> full=1 and count=4; then pop x4 -> rd_data 0xA..0xD, each with a one-cycle rd_valid; empty=1 at the end.
REQ-037 DEPTH=4, full FIFO: push 0xE while popping -> 0xE dropped, overflow=1, count=3; clr_err -> overflow=0.
REQ-038 Empty FIFO: push 0x5 and pop in the same cycle -> underflow=1, count=1, and the next pop returns 0x5.
REQ-039 FWFT=1: push 0x77 into empty -> next cycle rd_valid=1 and rd_data=0x77 with no pop issued; pop -> empty=1.
REQ-040 Wrap: 10 interleaved push/pop pairs with DEPTH=4 -> data order preserved and count stays at 1.
REQ-041 Reset with count=3 -> count=0, empty=1, and overflow and underflow cleared on the next cycle.
